// File: rtl/chal_responder.sv
// ---------------------------------------------------------------------------
// chal_responder
//
// Responder end of the UART challenge-response link.
// It parses "CHAL:" followed by 32 hex digits and LF from the uart_rx byte
// stream. The 128-bit challenge goes to an external ChaCha20 engine. The
// engine result is sent back as "RESP:" followed by 32 uppercase hex digits
// and LF through uart_tx. Host 'Y'/'N' command bytes are forwarded over the
// same TX path whenever the parser is idle.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   rx_data/_valid   byte stream from uart_rx (one-cycle strobe)
//   tx_data/_valid   byte to uart_tx (one-cycle strobe, data held)
//   tx_busy          uart_tx busy; a falling edge marks a byte as sent
//   cipher_start     one-cycle start pulse to the engine
//   cipher_ready     engine idle
//   cipher_in        captured challenge (plaintext)
//   cipher_out/valid engine result and its strobe
//   cmd_req/cmd_yes  request to send 'Y' (cmd_yes=1) or 'N'
//   resp_done        pulse after the final LF of a RESP frame has left uart_tx
//   parse_err        pulse on a malformed or timed-out CHAL frame
//   busy             high whenever the FSM is not hunting for a prefix
// ---------------------------------------------------------------------------
module chal_responder #(
   parameter logic [23:0] BYTE_TIMEOUT = 24'd1_200_000,
   parameter bit          ACCEPT_LOWER = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   rx_data,
   input  logic         rx_data_valid,
   output logic [7:0]   tx_data,
   output logic         tx_data_valid,
   input  logic         tx_busy,
   output logic         cipher_start,
   input  logic         cipher_ready,
   output logic [127:0] cipher_in,
   input  logic [127:0] cipher_out,
   input  logic         cipher_valid,
   input  logic         cmd_req,
   input  logic         cmd_yes,
   output logic         resp_done,
   output logic         parse_err,
   output logic         busy
);

   typedef enum logic [2:0] {HUNT, HEX, EOL, C_START, C_WAIT, SEND, CMD} state_t;

   state_t         state, state_n;
   logic [2:0]     pidx, pidx_n;
   logic [4:0]     nib_cnt, nib_cnt_n;
   logic [127:0]   cipher_in_n;
   logic [127:0]   result, result_n;
   logic [5:0]     tx_idx, tx_idx_n;
   logic [7:0]     tx_data_n;
   logic           tx_data_valid_n;
   logic           outstanding, outstanding_n;
   logic           busy_prev;
   logic [23:0]    timer, timer_n;
   logic           cmd_pend, cmd_pend_n;
   logic           cmd_val, cmd_val_n;
   logic           cmd_sel, cmd_sel_n;
   logic           cipher_start_n;
   logic           resp_done_n;
   logic           parse_err_n;

   logic           timed;
   logic           timeout;
   logic           tx_fall;
   logic           can_issue;
   logic [127:0]   shifted;
   logic [7:0]     send_byte;

   function automatic logic is_hex(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) ||
             (b >= 8'h41 && b <= 8'h46) ||
             (ACCEPT_LOWER && b >= 8'h61 && b <= 8'h66);
   endfunction

   // Letters share the low nibble pattern 1..6 in both cases, so +9 covers both.
   function automatic logic [3:0] hex_val(input logic [7:0] b);
      return (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
   endfunction

   function automatic logic [7:0] to_ascii(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
   endfunction

   function automatic logic [7:0] prefix_char(input logic [2:0] i);
      case (i)
         3'd0:    return 8'h43;
         3'd1:    return 8'h48;
         3'd2:    return 8'h41;
         3'd3:    return 8'h4C;
         default: return 8'h3A;
      endcase
   endfunction

   // The idle timer only runs while a CHAL frame is partially received.
   assign timed     = (state == HEX) || (state == EOL) || (state == HUNT && pidx != 3'd0);
   assign timeout   = timed && !rx_data_valid && (timer == BYTE_TIMEOUT - 24'd1);

   // A byte counts as sent on the falling edge of tx_busy. A new byte is only
   // offered when nothing is outstanding and the strobe from the previous
   // cycle has had a chance to raise tx_busy.
   assign tx_fall   = busy_prev && !tx_busy;
   assign can_issue = !outstanding && !tx_busy && !tx_data_valid;

   // Byte 5 carries result[127:124]; each later byte moves one nibble down.
   assign shifted   = result << {tx_idx - 6'd5, 2'b00};

   always_comb begin
      send_byte = 8'h0A;
      if (tx_idx < 6'd5) begin
         case (tx_idx)
            6'd0:    send_byte = 8'h52;
            6'd1:    send_byte = 8'h45;
            6'd2:    send_byte = 8'h53;
            6'd3:    send_byte = 8'h50;
            default: send_byte = 8'h3A;
         endcase
      end else if (tx_idx < 6'd37) begin
         send_byte = to_ascii(shifted[127:124]);
      end
   end

   // Next-state and next-output logic. Every registered value defaults to
   // holding, and every pulse defaults to zero.
   always_comb begin
      state_n         = state;
      pidx_n          = pidx;
      nib_cnt_n       = nib_cnt;
      cipher_in_n     = cipher_in;
      result_n        = result;
      tx_idx_n        = tx_idx;
      tx_data_n       = tx_data;
      tx_data_valid_n = 1'b0;
      outstanding_n   = outstanding;
      cmd_pend_n      = cmd_pend;
      cmd_val_n       = cmd_val;
      cmd_sel_n       = cmd_sel;
      cipher_start_n  = 1'b0;
      resp_done_n     = 1'b0;
      parse_err_n     = 1'b0;
      timer_n         = (rx_data_valid || !timed) ? 24'd0 : timer + 24'd1;

      case (state)
         HUNT: begin
            if (rx_data_valid) begin
               if (rx_data == prefix_char(pidx)) begin
                  if (pidx == 3'd4) begin
                     state_n   = HEX;
                     pidx_n    = 3'd0;
                     nib_cnt_n = 5'd0;
                  end else begin
                     pidx_n = pidx + 3'd1;
                  end
               end else begin
                  pidx_n = (rx_data == 8'h43) ? 3'd1 : 3'd0;
               end
            end else if (timeout) begin
               pidx_n = 3'd0;
            end
            // Commands are served only while no prefix is in progress.
            if (state_n == HUNT && pidx == 3'd0 && pidx_n == 3'd0 && cmd_pend) begin
               state_n    = CMD;
               cmd_pend_n = 1'b0;
               cmd_sel_n  = cmd_val;
            end
         end

         HEX: begin
            if (rx_data_valid) begin
               if (is_hex(rx_data)) begin
                  cipher_in_n = {cipher_in[123:0], hex_val(rx_data)};
                  nib_cnt_n   = nib_cnt + 5'd1;
                  if (nib_cnt == 5'd31) begin
                     state_n = EOL;
                  end
               end else begin
                  parse_err_n = 1'b1;
                  state_n     = HUNT;
                  pidx_n      = (rx_data == 8'h43) ? 3'd1 : 3'd0;
               end
            end else if (timeout) begin
               parse_err_n = 1'b1;
               state_n     = HUNT;
               pidx_n      = 3'd0;
            end
         end

         EOL: begin
            if (rx_data_valid) begin
               if (rx_data == 8'h0A) begin
                  state_n = C_START;
               end else if (rx_data != 8'h0D) begin
                  parse_err_n = 1'b1;
                  state_n     = HUNT;
                  pidx_n      = 3'd0;
               end
            end else if (timeout) begin
               parse_err_n = 1'b1;
               state_n     = HUNT;
               pidx_n      = 3'd0;
            end
         end

         C_START: begin
            if (cipher_ready) begin
               cipher_start_n = 1'b1;
               state_n        = C_WAIT;
            end
         end

         C_WAIT: begin
            if (cipher_valid) begin
               result_n = cipher_out;
               tx_idx_n = 6'd0;
               state_n  = SEND;
            end
         end

         SEND: begin
            if (outstanding && tx_fall) begin
               outstanding_n = 1'b0;
               if (tx_idx == 6'd37) begin
                  resp_done_n = 1'b1;
                  state_n     = HUNT;
                  pidx_n      = 3'd0;
               end else begin
                  tx_idx_n = tx_idx + 6'd1;
               end
            end else if (can_issue) begin
               tx_data_n       = send_byte;
               tx_data_valid_n = 1'b1;
               outstanding_n   = 1'b1;
            end
         end

         CMD: begin
            if (outstanding && tx_fall) begin
               outstanding_n = 1'b0;
               state_n       = HUNT;
               pidx_n        = 3'd0;
            end else if (can_issue) begin
               tx_data_n       = cmd_sel ? 8'h59 : 8'h4E;
               tx_data_valid_n = 1'b1;
               outstanding_n   = 1'b1;
            end
         end

         default: begin
            state_n = HUNT;
            pidx_n  = 3'd0;
         end
      endcase

      // A request that arrives in the same cycle as a serve stays pending,
      // and a later request replaces an earlier unserved one.
      if (cmd_req) begin
         cmd_pend_n = 1'b1;
         cmd_val_n  = cmd_yes;
      end
   end

   // State register. Reset returns to an idle parser with nothing pending
   // and all strobes low. A frame interrupted by reset is abandoned.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= HUNT;
         pidx          <= 3'd0;
         nib_cnt       <= 5'd0;
         cipher_in     <= 128'd0;
         result        <= 128'd0;
         tx_idx        <= 6'd0;
         tx_data       <= 8'd0;
         tx_data_valid <= 1'b0;
         outstanding   <= 1'b0;
         busy_prev     <= 1'b0;
         timer         <= 24'd0;
         cmd_pend      <= 1'b0;
         cmd_val       <= 1'b0;
         cmd_sel       <= 1'b0;
         cipher_start  <= 1'b0;
         resp_done     <= 1'b0;
         parse_err     <= 1'b0;
      end else begin
         state         <= state_n;
         pidx          <= pidx_n;
         nib_cnt       <= nib_cnt_n;
         cipher_in     <= cipher_in_n;
         result        <= result_n;
         tx_idx        <= tx_idx_n;
         tx_data       <= tx_data_n;
         tx_data_valid <= tx_data_valid_n;
         outstanding   <= outstanding_n;
         busy_prev     <= tx_busy;
         timer         <= timer_n;
         cmd_pend      <= cmd_pend_n;
         cmd_val       <= cmd_val_n;
         cmd_sel       <= cmd_sel_n;
         cipher_start  <= cipher_start_n;
         resp_done     <= resp_done_n;
         parse_err     <= parse_err_n;
      end
   end

   assign busy = (state != HUNT);

endmodule

// File: tb/tb_chal_responder.sv
// ---------------------------------------------------------------------------
// tb_chal_responder
//
// Self-checking bench for chal_responder. The main instance accepts lowercase
// hex. A second instance is built with lowercase rejected, and it is fed the
// same RX stream. Expected TX bytes are queued when a frame is driven. They
// are popped and compared as uart_tx accepts each byte.
// ---------------------------------------------------------------------------
module tb_chal_responder;

   localparam logic [127:0] ENGINE_RESULT = 128'h0123456789ABCDEF0011223344556677;
   localparam string        RESP_STR      = "RESP:0123456789ABCDEF0011223344556677\n";

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   rx_data;
   logic         rx_data_valid;
   logic [7:0]   tx_data;
   logic         tx_data_valid;
   logic         tx_busy = 1'b0;
   logic         cipher_start;
   logic         cipher_ready = 1'b1;
   logic [127:0] cipher_in;
   logic [127:0] cipher_out = 128'd0;
   logic         cipher_valid = 1'b0;
   logic         cmd_req;
   logic         cmd_yes;
   logic         resp_done;
   logic         parse_err;
   logic         busy;

   logic [7:0]   nl_tx_data;
   logic         nl_tx_data_valid;
   logic         nl_tx_busy = 1'b0;
   logic         nl_cipher_start;
   logic [127:0] nl_cipher_in;
   logic         nl_cipher_valid = 1'b0;
   logic         nl_resp_done;
   logic         nl_parse_err;
   logic         nl_busy;

   int checks = 0;
   int failures = 0;
   int tx_count = 0;
   int start_cnt = 0;
   int resp_cnt = 0;
   int perr_cnt = 0;
   int nl_start_cnt = 0;
   int nl_perr_cnt = 0;
   int busy_cnt = 0;
   int eng_cnt = 0;
   logic [7:0] exp_q[$];

   chal_responder #(.BYTE_TIMEOUT(24'd300), .ACCEPT_LOWER(1'b1)) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy),
      .cipher_start(cipher_start), .cipher_ready(cipher_ready),
      .cipher_in(cipher_in), .cipher_out(cipher_out), .cipher_valid(cipher_valid),
      .cmd_req(cmd_req), .cmd_yes(cmd_yes),
      .resp_done(resp_done), .parse_err(parse_err), .busy(busy)
   );

   chal_responder #(.BYTE_TIMEOUT(24'd300), .ACCEPT_LOWER(1'b0)) dut_nl (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .tx_data(nl_tx_data), .tx_data_valid(nl_tx_data_valid), .tx_busy(nl_tx_busy),
      .cipher_start(nl_cipher_start), .cipher_ready(1'b1),
      .cipher_in(nl_cipher_in), .cipher_out(128'd0), .cipher_valid(nl_cipher_valid),
      .cmd_req(1'b0), .cmd_yes(1'b0),
      .resp_done(nl_resp_done), .parse_err(nl_parse_err), .busy(nl_busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic pushExpect(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endtask

   task automatic sendByte(input logic [7:0] b);
      rx_data = b;
      rx_data_valid = 1'b1;
      @(posedge clk); #1;
      rx_data_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input string s);
      for (int i = 0; i < s.len(); i++) sendByte(s[i]);
   endtask

   task automatic waitResp(input int target);
      for (int i = 0; i < 3000 && resp_cnt < target; i++) begin
         @(posedge clk); #1;
      end
      checkOutput("resp_done_count", resp_cnt, target);
   endtask

   task automatic waitTx(input int target);
      for (int i = 0; i < 3000 && tx_count < target; i++) begin
         @(posedge clk); #1;
      end
      checkOutput("tx_byte_count", tx_count, target);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // uart_tx stand-in: takes a byte, then stays busy for 8 cycles.
   always @(negedge clk) begin
      if (tx_data_valid) begin
         checkOutput("tx_valid_while_busy", tx_busy, 1'b0);
         tx_count++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL tx_unexpected observed=%02h expected=none", tx_data);
         end else begin
            checkOutput("tx_byte", tx_data, exp_q.pop_front());
         end
         tx_busy = 1'b1;
         busy_cnt = 8;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy = 1'b0;
      end
   end

   // Engine stand-in: answers 40 cycles after a start pulse.
   always @(negedge clk) begin
      if (cipher_valid) begin
         cipher_valid = 1'b0;
         cipher_ready = 1'b1;
      end
      if (cipher_start) begin
         start_cnt++;
         cipher_ready = 1'b0;
         eng_cnt = 40;
      end else if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            cipher_out = ENGINE_RESULT;
            cipher_valid = 1'b1;
         end
      end
   end

   // Pulse counters, plus fast handshakes for the second instance.
   always @(negedge clk) begin
      if (resp_done) resp_cnt++;
      if (parse_err) perr_cnt++;
      if (nl_cipher_start) nl_start_cnt++;
      if (nl_parse_err) nl_perr_cnt++;
      nl_tx_busy = nl_tx_data_valid;
      nl_cipher_valid = nl_cipher_start;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base_tx, base_start, base_resp, base_perr, nl_p, nl_s;
      rst = 1'b1;
      rx_data = 8'h00;
      rx_data_valid = 1'b0;
      cmd_req = 1'b0;
      cmd_yes = 1'b0;
      idle(3);
      checkOutput("reset_tx_data_valid", tx_data_valid, 1'b0);
      checkOutput("reset_tx_data", tx_data, 8'h00);
      checkOutput("reset_cipher_start", cipher_start, 1'b0);
      checkOutput("reset_cipher_in", cipher_in, 128'd0);
      checkOutput("reset_resp_done", resp_done, 1'b0);
      checkOutput("reset_parse_err", parse_err, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      rst = 1'b0;
      idle(3);

      $display("[TB] uppercase frame");
      base_start = start_cnt;
      pushExpect(RESP_STR);
      applyStimulus("CHAL:00112233445566778899AABBCCDDEEFF\n");
      checkOutput("t1_busy_after_lf", busy, 1'b1);
      checkOutput("t1_cipher_in", cipher_in, 128'h00112233445566778899AABBCCDDEEFF);
      waitResp(1);
      checkOutput("t1_cipher_in_held", cipher_in, 128'h00112233445566778899AABBCCDDEEFF);
      checkOutput("t1_tx_count", tx_count, 38);
      checkOutput("t1_queue_empty", exp_q.size(), 0);
      checkOutput("t1_start_pulses", start_cnt - base_start, 1);
      idle(20);
      checkOutput("t1_resp_done_once", resp_cnt, 1);
      checkOutput("t1_busy_idle", busy, 1'b0);

      $display("[TB] lowercase frame with CR");
      base_start = start_cnt;
      base_tx = tx_count;
      nl_p = nl_perr_cnt;
      nl_s = nl_start_cnt;
      pushExpect(RESP_STR);
      applyStimulus("CHAL:00112233445566778899aabbccddeeff");
      sendByte(8'h0D);
      sendByte(8'h0A);
      checkOutput("t2_cipher_in", cipher_in, 128'h00112233445566778899AABBCCDDEEFF);
      waitResp(2);
      waitTx(base_tx + 38);
      checkOutput("t2_start_pulses", start_cnt - base_start, 1);
      checkOutput("t2_nl_parse_err", nl_perr_cnt - nl_p, 1);
      checkOutput("t2_nl_no_start", nl_start_cnt - nl_s, 0);
      idle(20);

      $display("[TB] resync on repeated C");
      base_tx = tx_count;
      pushExpect(RESP_STR);
      applyStimulus("CCHAL:FEDCBA9876543210FEDCBA9876543210\n");
      checkOutput("t3_cipher_in", cipher_in, 128'hFEDCBA9876543210FEDCBA9876543210);
      waitResp(3);
      waitTx(base_tx + 38);
      idle(20);

      $display("[TB] bad hex digit");
      base_tx = tx_count;
      base_perr = perr_cnt;
      base_start = start_cnt;
      applyStimulus("CHAL:12G");
      idle(60);
      checkOutput("t4_parse_err", perr_cnt - base_perr, 1);
      checkOutput("t4_no_tx", tx_count, base_tx);
      checkOutput("t4_no_start", start_cnt, base_start);
      checkOutput("t4_busy", busy, 1'b0);

      $display("[TB] inter-byte timeout");
      base_perr = perr_cnt;
      applyStimulus("CHAL:0123456789");
      idle(250);
      checkOutput("t5_no_err_early", perr_cnt - base_perr, 0);
      checkOutput("t5_busy_waiting", busy, 1'b1);
      idle(100);
      checkOutput("t5_parse_err", perr_cnt - base_perr, 1);
      checkOutput("t5_busy_after", busy, 1'b0);
      base_tx = tx_count;
      pushExpect(RESP_STR);
      applyStimulus("CHAL:00112233445566778899AABBCCDDEEFF\n");
      waitResp(4);
      waitTx(base_tx + 38);
      checkOutput("t5_no_more_err", perr_cnt - base_perr, 1);
      idle(20);

      $display("[TB] command during SEND, latest wins");
      base_tx = tx_count;
      pushExpect(RESP_STR);
      pushExpect("Y");
      applyStimulus("CHAL:00112233445566778899AABBCCDDEEFF\n");
      for (int i = 0; i < 2000 && tx_count < base_tx + 2; i++) begin
         @(posedge clk); #1;
      end
      cmd_yes = 1'b0;
      cmd_req = 1'b1;
      idle(1);
      cmd_req = 1'b0;
      idle(5);
      cmd_yes = 1'b1;
      cmd_req = 1'b1;
      idle(1);
      cmd_req = 1'b0;
      waitResp(5);
      waitTx(base_tx + 39);
      idle(100);
      checkOutput("t6_single_cmd_byte", tx_count, base_tx + 39);
      checkOutput("t6_queue_empty", exp_q.size(), 0);
      checkOutput("t6_last_byte", tx_data, 8'h59);

      $display("[TB] reset mid-SEND");
      base_tx = tx_count;
      pushExpect(RESP_STR);
      applyStimulus("CHAL:00112233445566778899AABBCCDDEEFF\n");
      for (int i = 0; i < 3000 && tx_count < base_tx + 12; i++) begin
         @(posedge clk); #1;
      end
      checkOutput("t7_bytes_before_reset", tx_count, base_tx + 12);
      rst = 1'b1;
      #1;
      checkOutput("t7_tx_valid_reset", tx_data_valid, 1'b0);
      checkOutput("t7_busy_reset", busy, 1'b0);
      checkOutput("t7_cipher_in_reset", cipher_in, 128'd0);
      exp_q.delete();
      idle(2);
      rst = 1'b0;
      idle(40);
      checkOutput("t7_no_resume", tx_count, base_tx + 12);
      base_resp = resp_cnt;
      base_tx = tx_count;
      pushExpect(RESP_STR);
      applyStimulus("CHAL:00112233445566778899AABBCCDDEEFF\n");
      waitResp(base_resp + 1);
      waitTx(base_tx + 38);
      checkOutput("t7_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/chal_responder.md
Name: chal_responder

Overview:
- Responder end of the UART challenge-response link. Parses "CHAL:" + 32 hex + LF from the uart_rx byte stream.
- Encrypts the 128-bit challenge through an external ChaCha20 engine (same key, zero nonce as the issuer) and transmits "RESP:" + 32 uppercase hex + LF through uart_tx.
- Also forwards host 'Y'/'N' control commands.
- Sits in the host-side FPGA, between the uart_rx/uart_tx instances and a chacha20_compact instance.

Parameters:
- BYTE_TIMEOUT, 24'd1_200_000: max idle cycles between bytes of a partial CHAL frame (100 ms at 12 MHz).
- ACCEPT_LOWER, 1: 1 = accept 'a'-'f' as hex digits in the challenge.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rx_data  in  8  byte from uart_rx
- rx_data_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to uart_tx
- tx_data_valid  out  1  one-cycle strobe to uart_tx
- tx_busy  in  1  uart_tx busy
- cipher_start  out  1  one-cycle start pulse to ChaCha20
- cipher_ready  in  1  engine idle
- cipher_in  out  128  captured challenge (plaintext)
- cipher_out  in  128  engine result
- cipher_valid  in  1  result valid strobe
- cmd_req  in  1  one-cycle request to send a command byte
- cmd_yes  in  1  sampled with cmd_req: 1 sends 'Y', 0 sends 'N'
- resp_done  out  1  one-cycle pulse after the LF of RESP leaves uart_tx
- parse_err  out  1  one-cycle pulse on malformed or timed-out frame
- busy  out  1  high in any state other than HUNT

Behaviour:
- Reset (async, rst=1) values: every output 0; cipher_in=0; FSM in HUNT; prefix index 0; pending command cleared. Release is synchronous to clk.
- FSM states: HUNT, HEX, EOL, C_START, C_WAIT, SEND, CMD.
- HUNT: match 'C','H','A','L',':' in order.
  - A mismatched byte resets the index to 0, except 'C', which sets it to 1.
  - No parse_err for noise in HUNT.
  - After ':' go to HEX with the nibble count at 0.
- HEX:
  - Each hex byte shifts its nibble into cipher_in LSB-first shift, so the first digit ends up in bits [127:124].
  - After 32 digits go to EOL.
  - A non-hex byte pulses parse_err and returns to HUNT. If that byte is 'C', the prefix index becomes 1.
- EOL:
  - 0x0D is ignored.
  - 0x0A goes to C_START.
  - Any other byte pulses parse_err and returns to HUNT.
- Inter-byte timeout (HEX, EOL, and HUNT with index>0):
  - Counter cleared on each rx_data_valid.
  - On reaching BYTE_TIMEOUT: go to HUNT, index 0; parse_err pulses only if the state was HEX or EOL.
- C_START: wait for cipher_ready=1, then pulse cipher_start for exactly 1 cycle and go to C_WAIT. cipher_in is held stable from the LF until SEND ends.
- C_WAIT: on cipher_valid, latch cipher_out into a 128-bit result register and go to SEND. No timeout.
- SEND: 38 bytes in order.
  - Bytes: 'R','E','S','P',':', then 32 uppercase hex of result[127:0] MSB nibble first, then 0x0A.
  - Per byte: pulse tx_data_valid for 1 cycle when tx_busy=0 and no byte is outstanding. tx_data is held until the next byte.
  - A byte is complete on the tx_busy falling edge, using a registered previous busy. The next byte is not issued before that edge.
  - After the LF's falling edge: pulse resp_done and return to HUNT.
- RX bytes received in C_START, C_WAIT, SEND and CMD are discarded, including a new CHAL. The parser restarts clean in HUNT.
- Commands:
  - cmd_req latches a one-entry pending slot holding cmd_yes. A later request overwrites it (latest wins).
  - The slot is served only from HUNT with prefix index 0: send 0x59 ('Y') or 0x4E ('N') via the same TX handshake in state CMD, clear the slot, return to HUNT.
  - If cmd_req arrives in the same cycle the slot is served, the new request stays pending.
- Simultaneous events:
  - rx_data_valid completing a ':' in HUNT takes priority over starting CMD.
  - The timeout and rx_data_valid in the same cycle: the byte wins.
- Reset mid-SEND or mid-CMD: tx_data_valid drops immediately. A partially transmitted frame is not resumed.

Test Plan:
- Feed "CHAL:00112233445566778899AABBCCDDEEFF\n"; model returns cipher_out=128'h0123456789ABCDEF0011223344556677 after 40 cycles → exactly one cipher_start pulse, cipher_in=128'h00112233445566778899AABBCCDDEEFF, TX emits "RESP:0123456789ABCDEF0011223344556677\n" (38 bytes), resp_done one pulse.
- "CHAL:00112233445566778899aabbccddeeff\r\n" with ACCEPT_LOWER=1 → same cipher_in as above, CR ignored; with ACCEPT_LOWER=0 → parse_err on 'a', no cipher_start.
- "CCHAL:" + 32 hex + "\n" → accepted (resync on 'C'). "CHAL:12G..." → parse_err at 'G', back to HUNT, no TX.
- 10 hex digits, then silence for BYTE_TIMEOUT cycles → one parse_err pulse; next full frame is processed normally.
- cmd_req with cmd_yes=0, then cmd_yes=1 while in SEND → after the RESP LF, exactly one 0x59 sent (latest wins), no 0x4E.
- Assert rst mid-SEND after 12 bytes → tx_data_valid=0, busy=0, state HUNT; next CHAL produces a full 38-byte RESP.
